// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter fed by two debounced active-low keys, with per-digit seg decode.
// Optional hold-to-repeat on each key: define REPEAT_EN.

module Debouncer #(
  parameter int N = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_clean
);
  localparam int CW = (N < 2) ? 1 : $clog2(N + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_clean;

  // The output follows the synchronised input only after N consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_clean <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(N - 1)) begin
        r_clean <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clean = r_clean;
endmodule

module SegDecoder (
  input  logic [3:0] i_digit,
  output logic [7:0] o_seg
);
  // Active-high segments, bit order {dp,g,f,e,d,c,b,a}.
  always_comb begin
    o_seg = 8'h00;
    case (i_digit)
      4'd0:    o_seg = 8'h3F;
      4'd1:    o_seg = 8'h06;
      4'd2:    o_seg = 8'h5B;
      4'd3:    o_seg = 8'h4F;
      4'd4:    o_seg = 8'h66;
      4'd5:    o_seg = 8'h6D;
      4'd6:    o_seg = 8'h7D;
      4'd7:    o_seg = 8'h07;
      4'd8:    o_seg = 8'h7F;
      4'd9:    o_seg = 8'h6F;
      default: o_seg = 8'h00;
    endcase
  end
endmodule

`ifdef REPEAT_EN
module RepeatFsm #(
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  input  logic i_press,
  input  logic i_clear,
  output logic o_step
);
  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_timer, w_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer;
    end
  end

  // The timer counts cycles spent in HOLD or RPT with the key still down.
  always_comb begin
    w_next  = r_state;
    w_timer = '0;
    o_step  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_press && !i_clear) begin
          w_next = HOLD;
          o_step = 1'b1;
        end
      end
      HOLD: begin
        if (i_key || i_clear) begin
          w_next = IDLE;
        end else if (r_timer == 32'(REPEAT_DLY - 1)) begin
          w_next = RPT;
          o_step = 1'b1;
        end else begin
          w_timer = r_timer + 32'd1;
        end
      end
      RPT: begin
        if (i_key || i_clear) begin
          w_next = IDLE;
        end else if (r_timer == 32'(REPEAT_PER - 1)) begin
          o_step = 1'b1;
        end else begin
          w_timer = r_timer + 32'd1;
        end
      end
      default: w_next = IDLE;
    endcase
  end
endmodule
`endif

module bcd_updown_counter #(
  parameter int DIGITS     = 2,
  parameter int MAX_VAL    = 99,
  parameter int WRAP       = 1,
  parameter int DEBOUNCE_N = 1000,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_up,
  input  logic                  key_dn,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [8*DIGITS-1:0]   seg_led,
  output logic                  wrap_pulse
);
  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] toBcd(input int v);
    logic [31:0] b;
    int          r;
    b = '0;
    r = v;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  localparam logic [31:0]         MAX_FULL = toBcd(MAX_VAL);
  localparam logic [4*DIGITS-1:0] MAX_BCD  = MAX_FULL[4*DIGITS-1:0];

  if (DIGITS < 1 || DIGITS > 8) begin : g_badDigits
    $error("bcd_updown_counter: DIGITS must be in 1..8");
  end
  if (MAX_VAL < 0 || MAX_VAL >= pow10(DIGITS)) begin : g_badMax
    $error("bcd_updown_counter: MAX_VAL must be below 10**DIGITS");
  end
  if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_badRepeat
    $error("bcd_updown_counter: REPEAT_DLY and REPEAT_PER must be positive");
  end

  function automatic logic [4*DIGITS-1:0] incBcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] decBcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic                w_debUp, w_debDn;
  logic                w_pressUp, w_pressDn;
  logic                w_reqUp, w_reqDn;
  logic                r_prevUp, r_prevDn;
  logic                r_stepUp, r_stepDn;
  logic [4*DIGITS-1:0] r_count, w_nextCount;
  logic                r_wrap, w_nextWrap;

  Debouncer #(.N(DEBOUNCE_N)) u_debUp (.clk(clk), .rst(rst), .i_raw(key_up), .o_clean(w_debUp));
  Debouncer #(.N(DEBOUNCE_N)) u_debDn (.clk(clk), .rst(rst), .i_raw(key_dn), .o_clean(w_debDn));

  assign w_pressUp = r_prevUp & ~w_debUp;
  assign w_pressDn = r_prevDn & ~w_debDn;

`ifdef REPEAT_EN
  logic w_rptUp, w_rptDn, w_bothHeld;

  RepeatFsm #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rptUp (
    .clk(clk), .rst(rst), .i_key(w_debUp), .i_press(w_pressUp), .i_clear(clear), .o_step(w_rptUp)
  );
  RepeatFsm #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_rptDn (
    .clk(clk), .rst(rst), .i_key(w_debDn), .i_press(w_pressDn), .i_clear(clear), .o_step(w_rptDn)
  );

  // With both keys down the timers keep running but neither key may step.
  assign w_bothHeld = ~w_debUp & ~w_debDn;
  assign w_reqUp    = w_rptUp & ~w_bothHeld;
  assign w_reqDn    = w_rptDn & ~w_bothHeld;
`else
  assign w_reqUp = w_pressUp;
  assign w_reqDn = w_pressDn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prevUp <= 1'b1;
      r_prevDn <= 1'b1;
      r_stepUp <= 1'b0;
      r_stepDn <= 1'b0;
      r_count  <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_prevUp <= w_debUp;
      r_prevDn <= w_debDn;
      r_stepUp <= w_reqUp;
      r_stepDn <= w_reqDn;
      r_count  <= w_nextCount;
      r_wrap   <= w_nextWrap;
    end
  end

  // Clear beats everything; opposing steps in the same cycle cancel.
  always_comb begin
    w_nextCount = r_count;
    w_nextWrap  = 1'b0;
    if (clear) begin
      w_nextCount = '0;
    end else if (r_stepUp && r_stepDn) begin
      w_nextCount = r_count;
    end else if (r_stepUp) begin
      if (r_count == MAX_BCD) begin
        if (WRAP != 0) begin
          w_nextCount = '0;
          w_nextWrap  = 1'b1;
        end
      end else begin
        w_nextCount = incBcd(r_count);
      end
    end else if (r_stepDn) begin
      if (r_count == '0) begin
        if (WRAP != 0) begin
          w_nextCount = MAX_BCD;
          w_nextWrap  = 1'b1;
        end
      end else begin
        w_nextCount = decBcd(r_count);
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    SegDecoder u_seg (.i_digit(r_count[4*g +: 4]), .o_seg(seg_led[8*g +: 8]));
  end

  assign count_bcd  = r_count;
  assign wrap_pulse = r_wrap;
endmodule
